// File: rtl/core_switch_arbiter_pkg.sv
// rtl/core_switch_arbiter_pkg.sv - shared encodings and constants for the core switch arbiter
`ifndef CSA_OSC_HZ
`define CSA_OSC_HZ 14745600
`endif

package core_switch_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_NONE  = 2'd0,
    ST_ACT_A = 2'd1,
    ST_ACT_B = 2'd2,
    ST_GUARD = 2'd3
  } csa_state_t;

  localparam int unsigned OSC_HZ       = `CSA_OSC_HZ;
  // Rounded to the nearest cycle so 14.7456 MHz gives 14746.
  localparam int unsigned CYCLES_1MS   = (OSC_HZ + 500) / 1000;
  localparam int          SWITCH_CNT_W = 16;
  localparam int          GUARD_CNT_W  = 24;

  localparam logic CORE_A = 1'b0;
  localparam logic CORE_B = 1'b1;

endpackage

// File: rtl/core_switch_arbiter_if.sv
// rtl/core_switch_arbiter_if.sv - health, force and selection signals of the core switch arbiter
interface core_switch_arbiter_if
  import core_switch_arbiter_pkg::*;
;
  logic                    a_ok;
  logic                    b_ok;
  logic                    force_en;
  logic                    force_sel;
  logic                    sel;
  logic                    out_en;
  logic                    switch_pulse;
  logic [1:0]              state;
  logic [SWITCH_CNT_W-1:0] switch_cnt;

  modport master (
    output a_ok, b_ok, force_en, force_sel,
    input  sel, out_en, switch_pulse, state, switch_cnt
  );

  modport slave (
    input  a_ok, b_ok, force_en, force_sel,
    output sel, out_en, switch_pulse, state, switch_cnt
  );

endinterface

// File: rtl/switch_guard_timer.sv
// rtl/switch_guard_timer.sv - break-before-make guard interval counter
module switch_guard_timer
  import core_switch_arbiter_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = CYCLES_1MS
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  // A zero-length guard still costs one cycle so outputs never overlap.
  localparam logic [GUARD_CNT_W-1:0] LAST =
    (GUARD_CYCLES == 0) ? '0 : GUARD_CNT_W'(GUARD_CYCLES - 1);

  logic [GUARD_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + GUARD_CNT_W'(1);
    end
  end

  assign done = enable && (count == LAST);

endmodule

// File: rtl/core_switch_arbiter.sv
// rtl/core_switch_arbiter.sv - dual-core health/force arbiter with guarded switchover
module core_switch_arbiter
  import core_switch_arbiter_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = CYCLES_1MS,
  parameter bit          REVERTIVE    = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  core_switch_arbiter_if.slave bus
);

  csa_state_t              state_q, state_d;
  logic                    tgt_q, tgt_d;
  logic                    guard_clear, guard_done, guard_en;
  logic                    tgt_ok;
  logic                    completing;
  logic                    sel_q, out_en_q, pulse_q;
  logic [SWITCH_CNT_W-1:0] switch_cnt_q;

  assign tgt_ok   = tgt_q ? bus.b_ok : bus.a_ok;
  assign guard_en = (state_q == ST_GUARD);

  switch_guard_timer #(
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (guard_clear),
    .enable(guard_en),
    .done  (guard_done)
  );

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    guard_clear = 1'b0;
    case (state_q)
      ST_NONE: begin
        if (bus.a_ok) begin
          state_d = ST_GUARD; tgt_d = CORE_A; guard_clear = 1'b1;
        end else if (bus.b_ok) begin
          state_d = ST_GUARD; tgt_d = CORE_B; guard_clear = 1'b1;
        end
      end
      // Health loss is checked before force so a dead core is always abandoned.
      ST_ACT_A: begin
        if (!bus.a_ok) begin
          if (bus.b_ok) begin
            state_d = ST_GUARD; tgt_d = CORE_B; guard_clear = 1'b1;
          end else begin
            state_d = ST_NONE;
          end
        end else if (bus.force_en && (bus.force_sel == CORE_B) && bus.b_ok) begin
          state_d = ST_GUARD; tgt_d = CORE_B; guard_clear = 1'b1;
        end
      end
      ST_ACT_B: begin
        if (!bus.b_ok) begin
          if (bus.a_ok) begin
            state_d = ST_GUARD; tgt_d = CORE_A; guard_clear = 1'b1;
          end else begin
            state_d = ST_NONE;
          end
        end else if (bus.force_en) begin
          if ((bus.force_sel == CORE_A) && bus.a_ok) begin
            state_d = ST_GUARD; tgt_d = CORE_A; guard_clear = 1'b1;
          end
        end else if (REVERTIVE && bus.a_ok) begin
          state_d = ST_GUARD; tgt_d = CORE_A; guard_clear = 1'b1;
        end
      end
      ST_GUARD: begin
        if (!bus.a_ok && !bus.b_ok) begin
          state_d = ST_NONE;
        end else if (!tgt_ok) begin
          tgt_d       = ~tgt_q;
          guard_clear = 1'b1;
        end else if (guard_done) begin
          state_d = tgt_q ? ST_ACT_B : ST_ACT_A;
        end
      end
      default: state_d = ST_NONE;
    endcase
  end

  assign completing = (state_q == ST_GUARD) &&
                      ((state_d == ST_ACT_A) || (state_d == ST_ACT_B));

  // Outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_NONE;
      tgt_q        <= CORE_A;
      sel_q        <= 1'b0;
      out_en_q     <= 1'b0;
      pulse_q      <= 1'b0;
      switch_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      out_en_q <= (state_d == ST_ACT_A) || (state_d == ST_ACT_B);
      sel_q    <= (state_d == ST_ACT_B) || ((state_d == ST_GUARD) && tgt_d);
      pulse_q  <= completing;
      if (completing && (switch_cnt_q != '1)) begin
        switch_cnt_q <= switch_cnt_q + SWITCH_CNT_W'(1);
      end
    end
  end

  assign bus.state        = state_q;
  assign bus.sel          = sel_q;
  assign bus.out_en       = out_en_q;
  assign bus.switch_pulse = pulse_q;
  assign bus.switch_cnt   = switch_cnt_q;

endmodule

// File: tb/tb_core_switch_arbiter.sv
// tb/tb_core_switch_arbiter.sv - scoreboard bench for core_switch_arbiter
module tb_core_switch_arbiter;
  import core_switch_arbiter_pkg::*;

  localparam int G = 4;

  typedef struct packed {
    logic        sel;
    logic [15:0] cnt;
  } sb_t;

  logic clk = 1'b0;
  logic rst, rv_hold, rst_rv;
  logic a_ok, b_ok, force_en, force_sel;
  int   n_tests = 0;
  int   n_fail  = 0;
  sb_t  sb_nr[$];
  sb_t  sb_rv[$];

  core_switch_arbiter_if bus_nr ();
  core_switch_arbiter_if bus_rv ();

  assign bus_nr.a_ok      = a_ok;
  assign bus_nr.b_ok      = b_ok;
  assign bus_nr.force_en  = force_en;
  assign bus_nr.force_sel = force_sel;
  assign bus_rv.a_ok      = a_ok;
  assign bus_rv.b_ok      = b_ok;
  assign bus_rv.force_en  = force_en;
  assign bus_rv.force_sel = force_sel;
  assign rst_rv           = rst | rv_hold;

  core_switch_arbiter #(.GUARD_CYCLES(G), .REVERTIVE(1'b0)) u_nr (
    .clk(clk), .rst(rst), .bus(bus_nr)
  );
  core_switch_arbiter #(.GUARD_CYCLES(G), .REVERTIVE(1'b1)) u_rv (
    .clk(clk), .rst(rst_rv), .bus(bus_rv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Snapshot layout: {state, sel, out_en, switch_pulse, switch_cnt}
  function automatic logic [31:0] mk(input logic [1:0] s, input logic sl, input logic oe,
                                     input logic p, input logic [15:0] c);
    return {11'd0, s, sl, oe, p, c};
  endfunction

  function automatic logic [31:0] snap(input bit rv);
    if (rv)
      return mk(bus_rv.state, bus_rv.sel, bus_rv.out_en, bus_rv.switch_pulse, bus_rv.switch_cnt);
    return mk(bus_nr.state, bus_nr.sel, bus_nr.out_en, bus_nr.switch_pulse, bus_nr.switch_cnt);
  endfunction

  function automatic logic [1:0] st(input bit rv);
    return rv ? bus_rv.state : bus_nr.state;
  endfunction

  // Called on the first GUARD cycle; counts cycles until the active state appears.
  task automatic wait_act(input bit rv, input logic [1:0] target, input string tag);
    int n;
    n = 0;
    while ((st(rv) != target) && (n < 4 * G + 8)) begin
      tick(1);
      n++;
    end
    chk({tag, "_state"}, 32'(st(rv)), 32'(target));
    chk({tag, "_guard_len"}, 32'(n), 32'(G));
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (bus_nr.switch_pulse) begin
      if (sb_nr.size() == 0) chk("nr_unexpected_pulse", 32'd1, 32'd0);
      else begin
        e = sb_nr.pop_front();
        chk("nr_pulse_sel", 32'(bus_nr.sel), 32'(e.sel));
        chk("nr_pulse_cnt", 32'(bus_nr.switch_cnt), 32'(e.cnt));
      end
    end
    if (bus_rv.switch_pulse) begin
      if (sb_rv.size() == 0) chk("rv_unexpected_pulse", 32'd1, 32'd0);
      else begin
        e = sb_rv.pop_front();
        chk("rv_pulse_sel", 32'(bus_rv.sel), 32'(e.sel));
        chk("rv_pulse_cnt", 32'(bus_rv.switch_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rv_hold = 1'b1;
    a_ok = 1'b1; b_ok = 1'b1; force_en = 1'b0; force_sel = 1'b0;
    tick(3);
    chk("reset", snap(0), mk(ST_NONE, 0, 0, 0, 16'd0));

    // Startup
    rst = 1'b0;
    sb_nr.push_back('{1'b0, 16'd1});
    chk("release_none", snap(0), mk(ST_NONE, 0, 0, 0, 16'd0));
    tick(1);
    chk("startup_guard", snap(0), mk(ST_GUARD, 0, 0, 0, 16'd0));
    wait_act(0, ST_ACT_A, "startup");
    chk("startup_act", snap(0), mk(ST_ACT_A, 0, 1, 1, 16'd1));
    tick(1);
    chk("startup_pulse_off", snap(0), mk(ST_ACT_A, 0, 1, 0, 16'd1));

    // Failover A -> B
    a_ok = 1'b0;
    sb_nr.push_back('{1'b1, 16'd2});
    tick(1);
    chk("failover_guard", snap(0), mk(ST_GUARD, 1, 0, 0, 16'd1));
    wait_act(0, ST_ACT_B, "failover");
    chk("failover_act", snap(0), mk(ST_ACT_B, 1, 1, 1, 16'd2));
    a_ok = 1'b1;
    tick(4);
    chk("nonrevertive_hold", snap(0), mk(ST_ACT_B, 1, 1, 0, 16'd2));

    // Forced switches
    force_en = 1'b1; force_sel = 1'b0;
    sb_nr.push_back('{1'b0, 16'd3});
    tick(1);
    chk("force_a_guard", snap(0), mk(ST_GUARD, 0, 0, 0, 16'd2));
    wait_act(0, ST_ACT_A, "force_a");
    chk("force_a_act", snap(0), mk(ST_ACT_A, 0, 1, 1, 16'd3));
    b_ok = 1'b0; force_sel = 1'b1;
    tick(4);
    chk("force_dead_ignored", snap(0), mk(ST_ACT_A, 0, 1, 0, 16'd3));
    b_ok = 1'b1;
    sb_nr.push_back('{1'b1, 16'd4});
    tick(1);
    chk("force_b_guard", snap(0), mk(ST_GUARD, 1, 0, 0, 16'd3));
    wait_act(0, ST_ACT_B, "force_b");
    chk("force_b_act", snap(0), mk(ST_ACT_B, 1, 1, 1, 16'd4));
    force_sel = 1'b0;
    sb_nr.push_back('{1'b0, 16'd5});
    tick(1);
    wait_act(0, ST_ACT_A, "force_back_a");
    force_en = 1'b0;
    tick(1);

    // Dual failure, then target loss mid-guard
    a_ok = 1'b0; b_ok = 1'b0;
    tick(1);
    chk("dual_fail", snap(0), mk(ST_NONE, 0, 0, 0, 16'd5));
    tick(3);
    chk("dual_fail_hold", snap(0), mk(ST_NONE, 0, 0, 0, 16'd5));
    b_ok = 1'b1;
    tick(1);
    chk("guard_tgt_b", snap(0), mk(ST_GUARD, 1, 0, 0, 16'd5));
    tick(2);
    b_ok = 1'b0; a_ok = 1'b1;
    sb_nr.push_back('{1'b0, 16'd6});
    tick(1);
    chk("tgt_flip", snap(0), mk(ST_GUARD, 0, 0, 0, 16'd5));
    wait_act(0, ST_ACT_A, "tgt_flip");
    chk("tgt_flip_act", snap(0), mk(ST_ACT_A, 0, 1, 1, 16'd6));

    // Reset mid-guard; both instances come out of reset together
    a_ok = 1'b0; b_ok = 1'b1;
    tick(1);
    chk("pre_rst_guard", snap(0), mk(ST_GUARD, 1, 0, 0, 16'd6));
    tick(1);
    rst = 1'b1; rv_hold = 1'b0;
    tick(1);
    chk("rst_mid_guard", snap(0), mk(ST_NONE, 0, 0, 0, 16'd0));
    chk("rv_in_reset", snap(1), mk(ST_NONE, 0, 0, 0, 16'd0));
    rst = 1'b0;
    sb_nr.push_back('{1'b1, 16'd1});
    sb_rv.push_back('{1'b1, 16'd1});
    tick(1);
    chk("post_rst_guard", snap(0), mk(ST_GUARD, 1, 0, 0, 16'd0));
    wait_act(0, ST_ACT_B, "post_rst");
    chk("post_rst_act", snap(0), mk(ST_ACT_B, 1, 1, 1, 16'd1));
    chk("rv_post_rst_act", snap(1), mk(ST_ACT_B, 1, 1, 1, 16'd1));

    // Revertive versus non-revertive under the same stimulus
    a_ok = 1'b1;
    sb_rv.push_back('{1'b0, 16'd2});
    tick(1);
    chk("revert_guard", snap(1), mk(ST_GUARD, 0, 0, 0, 16'd1));
    wait_act(1, ST_ACT_A, "revert");
    chk("revert_act", snap(1), mk(ST_ACT_A, 0, 1, 1, 16'd2));
    chk("nonrev_same_stim", snap(0), mk(ST_ACT_B, 1, 1, 0, 16'd1));
    force_en = 1'b1; force_sel = 1'b1;
    sb_rv.push_back('{1'b1, 16'd3});
    tick(1);
    wait_act(1, ST_ACT_B, "rv_force_b");
    tick(5);
    chk("revert_suppressed", snap(1), mk(ST_ACT_B, 1, 1, 0, 16'd3));
    force_en = 1'b0;
    sb_rv.push_back('{1'b0, 16'd4});
    tick(1);
    wait_act(1, ST_ACT_A, "revert_after_force");
    chk("revert_after_force_act", snap(1), mk(ST_ACT_A, 0, 1, 1, 16'd4));

    // Saturation of the switchover counter
    rv_hold = 1'b1;
    tick(1);
    force u_nr.switch_cnt_q = 16'hFFFD;
    tick(1);
    release u_nr.switch_cnt_q;
    tick(1);
    chk("preload", snap(0), mk(ST_ACT_B, 1, 1, 0, 16'hFFFD));
    force_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic        s;
      logic [15:0] prev, nxt;
      s    = (i == 1);
      prev = (i == 0) ? 16'hFFFD : ((i == 1) ? 16'hFFFE : 16'hFFFF);
      nxt  = (i == 0) ? 16'hFFFE : 16'hFFFF;
      force_sel = s;
      sb_nr.push_back('{s, nxt});
      tick(1);
      chk("sat_guard", snap(0), mk(ST_GUARD, s, 0, 0, prev));
      wait_act(0, s ? ST_ACT_B : ST_ACT_A, "sat");
      chk("sat_act", snap(0), mk(s ? ST_ACT_B : ST_ACT_A, s, 1, 1, nxt));
    end
    force_en = 1'b0;
    tick(2);

    chk("sb_nr_drained", 32'(sb_nr.size()), 32'd0);
    chk("sb_rv_drained", 32'(sb_rv.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
